// File: rtl/keypad_matrix_scanner_nkro.sv
// N-key-rollover matrix scanner: debounced per-key bitmap plus a press/release event stream.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat of the most recently pressed key.
module keypad_matrix_scanner_nkro #(
   parameter int NUM_ROWS      = 8,
   parameter int NUM_COLS      = 8,
   parameter int ROW_IDX_WIDTH = 3,
   parameter int COL_IDX_WIDTH = 3,
   parameter int CLK_DIV_WIDTH = 20,
   parameter int REPEAT_WIDTH  = 10
) (
   input  logic                         system_clk_i,
   input  logic                         system_rst_n_i,
   input  logic                         scan_enable_i,
   input  logic [CLK_DIV_WIDTH-1:0]     clk_divider_limit_i,
   input  logic [NUM_COLS-1:0]          keypad_columns_i,
   output logic [NUM_ROWS-1:0]          keypad_rows_o,
   output logic                         event_valid_o,
   input  logic                         event_ready_i,
   output logic                         event_press_o,
   output logic [ROW_IDX_WIDTH-1:0]     event_row_o,
   output logic [COL_IDX_WIDTH-1:0]     event_col_o,
   output logic [NUM_ROWS*NUM_COLS-1:0] key_state_o,
   output logic                         any_key_down_o,
   input  logic [REPEAT_WIDTH-1:0]      repeat_delay_i,
   input  logic [REPEAT_WIDTH-1:0]      repeat_period_i
);

   typedef enum logic [1:0] {ST_DISABLED, ST_SCAN, ST_EMIT} state_t;

   state_t                             state;
   logic [CLK_DIV_WIDTH-1:0]           div_cnt;
   logic                               tick;
   logic [ROW_IDX_WIDTH-1:0]           row_ptr, next_row;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0]  prev_raw, deb;
   logic [NUM_COLS-1:0]                mask, cur, change_mask, mask_after, emit_rest;
   logic [COL_IDX_WIDTH-1:0]           first_col, emit_col;
   logic                               rep_sel;
   logic                               rep_want;
   logic [ROW_IDX_WIDTH-1:0]           rep_row;
   logic [COL_IDX_WIDTH-1:0]           rep_col;

   function automatic logic [COL_IDX_WIDTH-1:0] lowest_bit(input logic [NUM_COLS-1:0] v);
      lowest_bit = '0;
      for (int i = NUM_COLS - 1; i >= 0; i--)
         if (v[i]) lowest_bit = COL_IDX_WIDTH'(i);
   endfunction

   function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_IDX_WIDTH-1:0] r);
      row_drive = ~(NUM_ROWS'(1) << r);
   endfunction

   assign tick           = (div_cnt == clk_divider_limit_i);
   assign cur            = ~keypad_columns_i;
   // A bit only counts as changed once two consecutive frame samples agree.
   assign change_mask    = (cur == prev_raw[row_ptr]) ? (cur ^ deb[row_ptr]) : '0;
   assign first_col      = lowest_bit(change_mask);
   assign mask_after     = mask & ~(NUM_COLS'(1) << event_col_o);
   assign emit_rest      = rep_sel ? mask : mask_after;
   assign emit_col       = lowest_bit(emit_rest);
   assign next_row       = (row_ptr == ROW_IDX_WIDTH'(NUM_ROWS - 1)) ? '0
                                                                     : row_ptr + ROW_IDX_WIDTH'(1);
   assign key_state_o    = deb;
   assign any_key_down_o = |deb;

   always_ff @(posedge system_clk_i or negedge system_rst_n_i) begin
      if (!system_rst_n_i)                         div_cnt <= '0;
      else if (state == ST_DISABLED || tick)       div_cnt <= '0;
      else                                         div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
   end

   // NOTE: every register here uses non-blocking assignment so all decisions see pre-edge values.
   always_ff @(posedge system_clk_i or negedge system_rst_n_i) begin
      if (!system_rst_n_i) begin
         // NOTE: the key arrays are ordinary flops, so they clear on reset like the rest of the state.
         state         <= ST_DISABLED;
         row_ptr       <= '0;
         prev_raw      <= '0;
         deb           <= '0;
         mask          <= '0;
         rep_sel       <= 1'b0;
         keypad_rows_o <= '1;
         event_valid_o <= 1'b0;
         event_press_o <= 1'b0;
         event_row_o   <= '0;
         event_col_o   <= '0;
      end else if (!scan_enable_i) begin
         state         <= ST_DISABLED;
         row_ptr       <= '0;
         mask          <= '0;
         rep_sel       <= 1'b0;
         keypad_rows_o <= '1;
         event_valid_o <= 1'b0;
      end else begin
         case (state)
            ST_DISABLED: begin
               state         <= ST_SCAN;
               keypad_rows_o <= row_drive(row_ptr);
            end
            ST_SCAN: if (tick) begin
               prev_raw[row_ptr] <= cur;
               if (change_mask != '0 || rep_want) begin
                  state         <= ST_EMIT;
                  mask          <= change_mask;
                  event_valid_o <= 1'b1;
                  if (rep_want) begin
                     rep_sel       <= 1'b1;
                     event_press_o <= 1'b1;
                     event_row_o   <= rep_row;
                     event_col_o   <= rep_col;
                  end else begin
                     event_press_o <= cur[first_col];
                     event_row_o   <= row_ptr;
                     event_col_o   <= first_col;
                  end
               end else begin
                  row_ptr       <= next_row;
                  keypad_rows_o <= row_drive(next_row);
               end
            end
            ST_EMIT: if (event_ready_i) begin
               mask    <= emit_rest;
               rep_sel <= 1'b0;
               if (!rep_sel) deb[row_ptr][event_col_o] <= ~deb[row_ptr][event_col_o];
               if (emit_rest != '0) begin
                  event_press_o <= ~deb[row_ptr][emit_col];
                  event_row_o   <= row_ptr;
                  event_col_o   <= emit_col;
               end else begin
                  state         <= ST_SCAN;
                  event_valid_o <= 1'b0;
                  row_ptr       <= next_row;
                  keypad_rows_o <= row_drive(next_row);
               end
            end
            default: state <= ST_DISABLED;
         endcase
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic                    rep_active, rep_first, rep_pending, rep_due, accept;
   logic [REPEAT_WIDTH-1:0] rep_cnt;

   assign accept   = (state == ST_EMIT) && event_ready_i && scan_enable_i;
   assign rep_due  = rep_active && tick && (state != ST_DISABLED) &&
                     (rep_cnt == (rep_first ? repeat_delay_i : repeat_period_i));
   assign rep_want = rep_pending || rep_due;

   // A due repeat stays pending until delivered; a new press restarts the delay.
   always_ff @(posedge system_clk_i or negedge system_rst_n_i) begin
      if (!system_rst_n_i) begin
         rep_active  <= 1'b0;
         rep_first   <= 1'b0;
         rep_pending <= 1'b0;
         rep_cnt     <= '0;
         rep_row     <= '0;
         rep_col     <= '0;
      end else if (!scan_enable_i) begin
         rep_active  <= 1'b0;
         rep_pending <= 1'b0;
      end else begin
         if (rep_due) begin
            rep_pending <= 1'b1;
            rep_cnt     <= '0;
            rep_first   <= 1'b0;
         end else if (rep_active && tick && state != ST_DISABLED) begin
            rep_cnt <= rep_cnt + REPEAT_WIDTH'(1);
         end
         if (accept && rep_sel) begin
            rep_pending <= rep_due;
         end else if (accept && event_press_o) begin
            rep_active  <= 1'b1;
            rep_first   <= 1'b1;
            rep_pending <= 1'b0;
            rep_cnt     <= '0;
            rep_row     <= event_row_o;
            rep_col     <= event_col_o;
         end else if (accept && rep_active && event_row_o == rep_row && event_col_o == rep_col) begin
            rep_active  <= 1'b0;
            rep_pending <= 1'b0;
         end
      end
   end
`else
   logic unused_repeat;
   assign unused_repeat = ^{repeat_delay_i, repeat_period_i};
   assign rep_want      = 1'b0;
   assign rep_row       = '0;
   assign rep_col       = '0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner_nkro.sv
// Directed bench for keypad_matrix_scanner_nkro: a simple 8x8 switch-matrix model drives the columns.
module tb_keypad_matrix_scanner_nkro;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          scan_enable;
   logic [19:0]   limit;
   logic [7:0]    cols;
   logic [7:0]    rows;
   logic          valid, ready, press;
   logic [2:0]    row, col;
   logic [63:0]   key_state;
   logic          any_key;
   logic [9:0]    rep_delay, rep_period;

   logic [7:0][7:0] pressed;
   logic            cols_force;

   logic [6:0] evq[$];
   int         evt[$];
   int         cyc = 0;
   int         total = 0, passed = 0, failed = 0;

   always #5 clk = ~clk;

   keypad_matrix_scanner_nkro dut (
      .system_clk_i        (clk),
      .system_rst_n_i      (rst_n),
      .scan_enable_i       (scan_enable),
      .clk_divider_limit_i (limit),
      .keypad_columns_i    (cols),
      .keypad_rows_o       (rows),
      .event_valid_o       (valid),
      .event_ready_i       (ready),
      .event_press_o       (press),
      .event_row_o         (row),
      .event_col_o         (col),
      .key_state_o         (key_state),
      .any_key_down_o      (any_key),
      .repeat_delay_i      (rep_delay),
      .repeat_period_i     (rep_period)
   );

   // Closed switch shorts a driven-low row onto its column.
   always_comb begin
      cols = '1;
      for (int r = 0; r < 8; r++)
         if (!rows[r]) cols = cols & ~pressed[r];
      if (cols_force) cols = '0;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (valid && ready) begin
         evq.push_back({press, row, col});
         evt.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ev(input string tag, input int idx, input logic p, input int r, input int c);
      logic [6:0] got;
      got = (idx < evq.size()) ? evq[idx] : 7'h7f;
      check(tag, 64'(got), 64'({p, 3'(r), 3'(c)}));
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_events(input int n, input int budget, input string tag);
      int k = 0;
      while (evq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(evq.size()), 64'(n));
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int k = 0;
      while (valid !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(valid), 64'(1));
   endtask

   task automatic wait_rows(input logic [7:0] target, input int budget, input string tag);
      int k = 0;
      while (rows !== target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(rows), 64'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_rows;
      int         gap;

      rst_n       = 1'b0;
      scan_enable = 1'b1;
      limit       = 20'd3;
      ready       = 1'b1;
      pressed     = '0;
      cols_force  = 1'b1;
      rep_delay   = '0;
      rep_period  = '0;

      // Reset state with every column pulled low.
      clks(3);
      check("rst_rows", 64'(rows), 64'hFF);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_key_state", key_state, 64'd0);
      check("rst_any", 64'(any_key), 64'd0);
      check("rst_press", 64'(press), 64'd0);
      check("rst_row", 64'(row), 64'd0);
      check("rst_col", 64'(col), 64'd0);

      cols_force = 1'b0;
      rst_n      = 1'b1;

      // Rows walk FE..7F, four clocks each, then wrap.
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if ((k - 1) % 4 == 0) begin
            exp_rows = 8'b1 << (((k - 1) / 4) % 8);
            exp_rows = ~exp_rows;
            check($sformatf("scan_rows_k%0d", k), 64'(rows), 64'(exp_rows));
         end
      end

      // Single press at row 2 / column 5, then release.
      pressed[2][5] = 1'b1;
      wait_events(1, 100, "press_seen");
      clks(64);
      check("press_only_one", 64'(evq.size()), 64'd1);
      check_ev("press_ev", 0, 1'b1, 2, 5);
      check("press_key_state", key_state, 64'h0000_0000_0020_0000);
      check("press_any", 64'(any_key), 64'd1);
      pressed[2][5] = 1'b0;
      wait_events(2, 100, "release_seen");
      clks(64);
      check("release_only_one", 64'(evq.size()), 64'd2);
      check_ev("release_ev", 1, 1'b0, 2, 5);
      check("release_key_state", key_state, 64'd0);

      // Bounce: row 1 / column 0 flips once per frame, never two agreeing samples.
      for (int i = 0; i < 6; i++) begin
         pressed[1][0] = ~pressed[1][0];
         clks(32);
      end
      clks(64);
      check("bounce_no_event", 64'(evq.size()), 64'd2);
      check("bounce_key_state", key_state, 64'd0);

      // Three keys in row 4 under backpressure.
      ready         = 1'b0;
      pressed[4][1] = 1'b1;
      pressed[4][3] = 1'b1;
      pressed[4][6] = 1'b1;
      wait_valid(100, "multi_valid");
      for (int i = 0; i < 10; i++) begin
         check($sformatf("multi_stall_%0d", i), 64'({valid, press, row, col}), 64'({1'b1, 1'b1, 3'd4, 3'd1}));
         @(negedge clk);
      end
      check("multi_no_accept", 64'(evq.size()), 64'd2);
      ready = 1'b1;
      wait_events(5, 20, "multi_accepts");
      check_ev("multi_ev_c1", 2, 1'b1, 4, 1);
      check_ev("multi_ev_c3", 3, 1'b1, 4, 3);
      check_ev("multi_ev_c6", 4, 1'b1, 4, 6);
      gap = (evt.size() >= 5) ? evt[3] - evt[2] : -1;
      check("multi_gap_1", 64'(gap), 64'd1);
      gap = (evt.size() >= 5) ? evt[4] - evt[3] : -1;
      check("multi_gap_2", 64'(gap), 64'd1);
      check("multi_key_state", key_state, 64'h0000_004A_0000_0000);
      wait_rows(8'hFE, 64, "multi_scan_resumes");
      pressed[4] = '0;
      wait_events(8, 100, "multi_release");
      check_ev("multi_rel_c1", 5, 1'b0, 4, 1);
      check_ev("multi_rel_c3", 6, 1'b0, 4, 3);
      check_ev("multi_rel_c6", 7, 1'b0, 4, 6);
      check("multi_rel_key_state", key_state, 64'd0);

      // Disable while an event is pending, then re-enable with the key held.
      ready         = 1'b0;
      pressed[6][2] = 1'b1;
      wait_valid(100, "dis_valid");
      scan_enable = 1'b0;
      @(negedge clk);
      check("dis_valid_drop", 64'(valid), 64'd0);
      check("dis_rows", 64'(rows), 64'hFF);
      clks(5);
      check("dis_no_accept", 64'(evq.size()), 64'd8);
      ready       = 1'b1;
      scan_enable = 1'b1;
      wait_events(9, 120, "reen_event");
      check_ev("reen_ev", 8, 1'b1, 6, 2);
      clks(96);
      check("reen_no_dup", 64'(evq.size()), 64'd9);
      check("reen_key_state", key_state, 64'h0004_0000_0000_0000);
      pressed[6][2] = 1'b0;
      wait_events(10, 100, "reen_release");
      check_ev("reen_rel_ev", 9, 1'b0, 6, 2);

      // Keys in different rows are reported in scan order.
      wait_rows(8'hFE, 64, "order_sync");
      pressed[5][0] = 1'b1;
      pressed[3][7] = 1'b1;
      wait_events(12, 120, "order_press");
      check_ev("order_press_r3", 10, 1'b1, 3, 7);
      check_ev("order_press_r5", 11, 1'b1, 5, 0);
      pressed[5][0] = 1'b0;
      pressed[3][7] = 1'b0;
      wait_events(14, 120, "order_release");
      check_ev("order_rel_r3", 12, 1'b0, 3, 7);
      check_ev("order_rel_r5", 13, 1'b0, 5, 0);

      // limit = 0: a new row every clock.
      scan_enable = 1'b0;
      @(negedge clk);
      limit = 20'd0;
      clks(2);
      scan_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_rows = 8'b1 << i;
         exp_rows = ~exp_rows;
         check($sformatf("fast_rows_%0d", i), 64'(rows), 64'(exp_rows));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
